// File: rtl/input_act_pkg.sv
// ============================================================================
// Module  : input_act_pkg
// Brief   : Shared types and sizing helpers for the replaying activation feeder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package input_act_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sub-phase inside FEED; only used when zero padding is built in.
  typedef enum logic {
    PH_DATA = 1'b0,
    PH_PAD  = 1'b1
  } phase_t;

  function automatic int slice_count(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/act_replay_buffer.sv
// ============================================================================
// Module  : act_replay_buffer
// Brief   : Circular word store with a replay mark; words stay resident until freed.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module act_replay_buffer
  import input_act_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int PW    = ptr_width(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_adv,
  input  logic             set_mark,
  input  logic             rewind,
  input  logic             free,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    mark_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_ok;

  // Fullness is judged on the pre-edge count, so a same-cycle free does not make room.
  assign wr_ok   = wr_en && !full;
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mark_ptr <= '0;
      cnt      <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mark_ptr <= '0;
      cnt      <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (set_mark) begin
        mark_ptr <= rd_ptr;
      end
      if (rewind) begin
        rd_ptr <= mark_ptr;
      end else if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, free})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/input_act_ctrl_replay.sv
// ============================================================================
// Module  : input_act_ctrl_replay
// Brief   : Buffers wide activation words and streams them as narrow beats with
//           multi-pass replay; INPUT_ACT_CTRL_PAD_EN adds zero padding per pass.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module input_act_ctrl_replay
  import input_act_pkg::*;
#(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 64,
  parameter int REPEAT_WIDTH = 4
) (
  input  logic                             CLK,
  input  logic                             RESETN,
  input  logic                             CLEAR_FIFO,
  input  logic                             FIFO_WR_CMD,
  input  logic [INPUT_WIDTH-1:0]           FIFO_WR_DATA,
  output logic                             FIFO_EMPTY,
  output logic                             FIFO_FULL,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  FIFO_COUNT,
  input  logic                             START_FEED,
  input  logic [REPEAT_WIDTH-1:0]          FEED_REPEAT,
`ifdef INPUT_ACT_CTRL_PAD_EN
  input  logic [7:0]                       PAD_BEATS,
`endif
  input  logic                             OUT_READY,
  output logic [OUTPUT_WIDTH-1:0]          IN_ACT_DATA_OUT,
  output logic                             DATA_VALID,
  output logic                             FEED_BUSY,
  output logic                             FEED_DONE
);

  localparam int S  = slice_count(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] LAST_SLICE = SW'(S - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [SW-1:0]           slice_cnt;
  logic [CW-1:0]           word_cnt;
  logic [CW-1:0]           n_words;
  logic [REPEAT_WIDTH-1:0] rep_total;
  logic [REPEAT_WIDTH-1:0] pass_cnt;

  logic                    start;
  logic                    rd_adv;
  logic                    rewind;
  logic                    free;
  logic                    pass_end;
  logic                    fire;
  logic                    data_fire;
  logic                    data_ends_pass;
  logic                    last_slice;
  logic                    last_word;
  logic                    final_pass;
  logic [INPUT_WIDTH-1:0]  rd_data;
  logic [OUTPUT_WIDTH-1:0] cur_slice;
  logic [CW-1:0]           buf_count;
  logic                    buf_empty;

  act_replay_buffer #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk      (CLK),
    .rst_n    (RESETN),
    .clear    (CLEAR_FIFO),
    .wr_en    (FIFO_WR_CMD),
    .wr_data  (FIFO_WR_DATA),
    .rd_adv   (rd_adv),
    .set_mark (start),
    .rewind   (rewind),
    .free     (free),
    .rd_data  (rd_data),
    .count    (buf_count),
    .full     (FIFO_FULL),
    .empty    (buf_empty)
  );

  assign FIFO_COUNT = buf_count;
  assign FIFO_EMPTY = buf_empty;
  assign DATA_VALID = (state == FEED);
  assign FEED_BUSY  = (state != IDLE);
  assign FEED_DONE  = (state == DONE);

  assign fire       = DATA_VALID && OUT_READY;
  assign last_slice = (slice_cnt == LAST_SLICE);
  assign last_word  = (word_cnt == n_words - 1'b1);
  assign final_pass = (pass_cnt == rep_total);
  assign cur_slice  = rd_data[32'(slice_cnt) * OUTPUT_WIDTH +: OUTPUT_WIDTH];

`ifdef INPUT_ACT_CTRL_PAD_EN
  phase_t     phase;
  logic [7:0] pad_n;
  logic [7:0] pad_cnt;
  logic       pad_fire;
  logic       pad_last;

  assign data_fire       = fire && (phase == PH_DATA);
  assign pad_fire        = fire && (phase == PH_PAD);
  assign pad_last        = (pad_cnt == pad_n - 8'd1);
  assign data_ends_pass  = (pad_n == 8'd0);
  assign IN_ACT_DATA_OUT = (DATA_VALID && (phase == PH_DATA)) ? cur_slice : '0;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      phase   <= PH_DATA;
      pad_n   <= '0;
      pad_cnt <= '0;
    end else if (CLEAR_FIFO) begin
      phase   <= PH_DATA;
      pad_cnt <= '0;
    end else if (start) begin
      phase   <= PH_DATA;
      pad_cnt <= '0;
      pad_n   <= PAD_BEATS;
    end else if (data_fire && last_slice && last_word && (pad_n != 8'd0)) begin
      phase <= PH_PAD;
    end else if (pad_fire) begin
      if (pad_last) begin
        phase   <= PH_DATA;
        pad_cnt <= '0;
      end else begin
        pad_cnt <= pad_cnt + 8'd1;
      end
    end
  end
`else
  assign data_fire       = fire;
  assign data_ends_pass  = 1'b1;
  assign IN_ACT_DATA_OUT = DATA_VALID ? cur_slice : '0;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
    end else if (CLEAR_FIFO) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    rd_adv   = 1'b0;
    rewind   = 1'b0;
    free     = 1'b0;
    pass_end = 1'b0;
    case (state)
      IDLE: begin
        if (START_FEED && !buf_empty) begin
          state_nx = FEED;
          start    = 1'b1;
        end
      end
      FEED: begin
        // Final pass frees each word as its top slice leaves; earlier passes rewind.
        if (data_fire && last_slice) begin
          free = final_pass;
          if (!last_word) begin
            rd_adv = 1'b1;
          end else begin
            rd_adv   = final_pass;
            rewind   = !final_pass;
            pass_end = data_ends_pass;
          end
        end
`ifdef INPUT_ACT_CTRL_PAD_EN
        if (pad_fire && pad_last) begin
          pass_end = 1'b1;
        end
`endif
        if (pass_end && final_pass) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      slice_cnt <= '0;
      word_cnt  <= '0;
      n_words   <= '0;
      rep_total <= '0;
      pass_cnt  <= '0;
    end else if (CLEAR_FIFO) begin
      slice_cnt <= '0;
      word_cnt  <= '0;
      pass_cnt  <= '0;
    end else if (start) begin
      slice_cnt <= '0;
      word_cnt  <= '0;
      pass_cnt  <= '0;
      n_words   <= buf_count;
      rep_total <= FEED_REPEAT;
    end else begin
      if (data_fire) begin
        slice_cnt <= last_slice ? '0 : slice_cnt + 1'b1;
        if (last_slice) begin
          word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        end
      end
      if (pass_end && !final_pass) begin
        pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_input_act_ctrl_replay.sv
// ============================================================================
// Module  : tb_input_act_ctrl_replay
// Brief   : Self-checking bench: vector table, randomized feeds vs a queue model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_input_act_ctrl_replay;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        CLEAR_FIFO;
  logic        FIFO_WR_CMD;
  logic [31:0] FIFO_WR_DATA;
  logic        FIFO_EMPTY;
  logic        FIFO_FULL;
  logic [6:0]  FIFO_COUNT;
  logic        START_FEED;
  logic [3:0]  FEED_REPEAT;
`ifdef INPUT_ACT_CTRL_PAD_EN
  logic [7:0]  PAD_BEATS;
`endif
  logic        OUT_READY;
  logic [7:0]  IN_ACT_DATA_OUT;
  logic        DATA_VALID;
  logic        FEED_BUSY;
  logic        FEED_DONE;

  always #5 CLK = ~CLK;

  input_act_ctrl_replay dut (
    .CLK             (CLK),
    .RESETN          (RESETN),
    .CLEAR_FIFO      (CLEAR_FIFO),
    .FIFO_WR_CMD     (FIFO_WR_CMD),
    .FIFO_WR_DATA    (FIFO_WR_DATA),
    .FIFO_EMPTY      (FIFO_EMPTY),
    .FIFO_FULL       (FIFO_FULL),
    .FIFO_COUNT      (FIFO_COUNT),
    .START_FEED      (START_FEED),
    .FEED_REPEAT     (FEED_REPEAT),
`ifdef INPUT_ACT_CTRL_PAD_EN
    .PAD_BEATS       (PAD_BEATS),
`endif
    .OUT_READY       (OUT_READY),
    .IN_ACT_DATA_OUT (IN_ACT_DATA_OUT),
    .DATA_VALID      (DATA_VALID),
    .FEED_BUSY       (FEED_BUSY),
    .FEED_DONE       (FEED_DONE)
  );

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          rep;
    int          pct;
    int          exp_beats;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          tests = 0;
  int          fails = 0;
  int          wr_at[2];
  logic [31:0] wr_word[2];
  int          post_wr_count;

  task automatic check(input string nm, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    FIFO_WR_CMD  = 1'b1;
    FIFO_WR_DATA = w;
    if (fifo_q.size() < 64) fifo_q.push_back(w);
    tick();
    FIFO_WR_CMD = 1'b0;
  endtask

  // Words released so far: only the last pass frees, one word per four beats.
  function automatic int freed_words(input int g, input int rep, input int n, input int pad);
    int fs;
    int f;
    fs = rep * (n * 4 + pad);
    if (g <= fs) return 0;
    f = (g - fs) / 4;
    return (f > n) ? n : f;
  endfunction

  task automatic do_feed(input int rep, input int pad, input int pct);
    int          n;
    int          cyc;
    int          bound;
    int          vcyc;
    int          stall_err;
    int          cnt_err;
    int          drop_err;
    int          first_bad;
    bit          done;
    bit          prev_stall;
    bit          lat_ok;
    bit          pend;
    bit          just_wrote;
    bit          wr_done[2];
    logic [7:0]  prev_data;
    logic [31:0] pend_w;
    logic [31:0] w;

    n = fifo_q.size();
    exp_q.delete();
    got_q.delete();
    for (int p = 0; p <= rep; p++) begin
      for (int i = 0; i < n; i++) begin
        w = fifo_q[i];
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k*8 +: 8]);
      end
      for (int z = 0; z < pad; z++) exp_q.push_back(8'h00);
    end

    FEED_REPEAT = 4'(rep);
`ifdef INPUT_ACT_CTRL_PAD_EN
    PAD_BEATS = 8'(pad);
`endif
    START_FEED = 1'b1;
    tick();
    START_FEED = 1'b0;

    bound = exp_q.size() * 20 + 50;
    cyc = 0; vcyc = 0; stall_err = 0; cnt_err = 0; drop_err = 0;
    done = 1'b0; prev_stall = 1'b0; lat_ok = 1'b0; pend = 1'b0;
    wr_done[0] = 1'b0; wr_done[1] = 1'b0; prev_data = '0;
    while (!done && cyc < bound) begin
      FIFO_WR_CMD = 1'b0;
      just_wrote  = 1'b0;
      if (pend) begin
        fifo_q.push_back(pend_w);
        pend = 1'b0;
        just_wrote = 1'b1;
      end
      for (int j = 0; j < 2; j++) begin
        if (!wr_done[j] && wr_at[j] >= 0 && got_q.size() == wr_at[j]) begin
          FIFO_WR_CMD  = 1'b1;
          FIFO_WR_DATA = wr_word[j];
          wr_done[j]   = 1'b1;
          if (fifo_q.size() - freed_words(got_q.size(), rep, n, pad) < 64) begin
            pend   = 1'b1;
            pend_w = wr_word[j];
          end
        end
      end
      OUT_READY = ($urandom_range(99) < pct);
      @(negedge CLK);
      if (cyc == 0) lat_ok = DATA_VALID;
      if (just_wrote) post_wr_count = int'(FIFO_COUNT);
      if (int'(FIFO_COUNT) != fifo_q.size() - freed_words(got_q.size(), rep, n, pad)) cnt_err++;
      if (FEED_DONE) begin
        done = 1'b1;
        if (DATA_VALID) drop_err++;
      end else begin
        if (!DATA_VALID) drop_err++;
        if (prev_stall && IN_ACT_DATA_OUT != prev_data) stall_err++;
        if (DATA_VALID && OUT_READY) got_q.push_back(IN_ACT_DATA_OUT);
        if (DATA_VALID) vcyc++;
        prev_stall = DATA_VALID && !OUT_READY;
        prev_data  = IN_ACT_DATA_OUT;
      end
      @(posedge CLK);
      #1;
      cyc++;
    end
    FIFO_WR_CMD = 1'b0;
    if (pend) fifo_q.push_back(pend_w);
    wr_at[0] = -1;
    wr_at[1] = -1;

    check("feed_done_seen", done, 1);
    check("start_latency", lat_ok, 1);
    check("beat_count", got_q.size(), exp_q.size());
    first_bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (first_bad < 0 && got_q[i] != exp_q[i]) first_bad = i;
    end
    check("stream_first_bad_index", first_bad, -1);
    check("stall_hold_errors", stall_err, 0);
    check("valid_drop_errors", drop_err, 0);
    check("count_track_errors", cnt_err, 0);
    if (pct == 100) check("no_bubble_cycles", vcyc, exp_q.size());

    if (!done) begin
      CLEAR_FIFO = 1'b1;
      tick();
      CLEAR_FIFO = 1'b0;
      fifo_q.delete();
    end else begin
      for (int i = 0; i < n; i++) void'(fifo_q.pop_front());
    end

    @(negedge CLK);
    check("done_single_pulse", FEED_DONE, 0);
    check("idle_after_done", FEED_BUSY, 0);
    @(posedge CLK);
    #1;
    check("count_after_feed", FIFO_COUNT, fifo_q.size());
    check("empty_after_feed", FIFO_EMPTY, fifo_q.size() == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   done_err;

    RESETN = 1'b0; CLEAR_FIFO = 1'b0; FIFO_WR_CMD = 1'b0; FIFO_WR_DATA = '0;
    START_FEED = 1'b0; FEED_REPEAT = '0; OUT_READY = 1'b0;
`ifdef INPUT_ACT_CTRL_PAD_EN
    PAD_BEATS = '0;
`endif
    wr_at[0] = -1; wr_at[1] = -1;
    wr_word[0] = '0; wr_word[1] = '0;
    post_wr_count = -1;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_empty", FIFO_EMPTY, 1);
    check("rst_full", FIFO_FULL, 0);
    check("rst_count", FIFO_COUNT, 0);
    check("rst_valid", DATA_VALID, 0);
    check("rst_busy", FEED_BUSY, 0);
    check("rst_done", FEED_DONE, 0);
    check("rst_data", IN_ACT_DATA_OUT, 0);
    RESETN = 1'b1;
    tick();

    // Directed two-word feeds.
    tbl[0] = '{32'h44332211, 32'h88776655, 0, 100, 8,  8'h11, 8'h88};
    tbl[1] = '{32'h44332211, 32'h88776655, 2, 100, 24, 8'h11, 8'h88};
    tbl[2] = '{32'hA1B2C3D4, 32'h0F1E2D3C, 1, 50,  16, 8'hD4, 8'h0F};
    tbl[3] = '{32'hFFFFFFFF, 32'h00000000, 0, 30,  8,  8'hFF, 8'h00};
    for (int v = 0; v < 4; v++) begin
      write_word(tbl[v].w0);
      write_word(tbl[v].w1);
      check("tbl_count_before", FIFO_COUNT, 2);
      do_feed(tbl[v].rep, 0, tbl[v].pct);
      check("tbl_total_beats", got_q.size(), tbl[v].exp_beats);
      if (got_q.size() > 0) begin
        check("tbl_first_beat", got_q[0], tbl[v].exp_first);
        check("tbl_last_beat", got_q[got_q.size()-1], tbl[v].exp_last);
      end
    end

    // Random data under random backpressure; second batch crosses the pointer wrap.
    for (int i = 0; i < 21; i++) write_word($urandom);
    do_feed(0, 0, 50);
    for (int i = 0; i < 45; i++) write_word($urandom);
    do_feed(1, 0, 60);
    write_word($urandom);
    do_feed(15, 0, 80);

    // Fill to capacity, drop on full, refill after the first free.
    for (int i = 0; i < 64; i++) write_word($urandom);
    check("full_flag", FIFO_FULL, 1);
    check("full_count", FIFO_COUNT, 64);
    write_word(32'hBADBAD00);
    check("drop_when_full_count", FIFO_COUNT, 64);
    wr_at[0] = 3; wr_word[0] = 32'hBADBAD01;
    wr_at[1] = 4; wr_word[1] = 32'hC0FFEE42;
    post_wr_count = -1;
    do_feed(0, 0, 100);
    check("refill_count", post_wr_count, 64);
    check("leftover_count", FIFO_COUNT, 1);
    do_feed(0, 0, 100);
    if (got_q.size() > 3) check("leftover_word_top", got_q[3], 8'hC0);

    // Clear in the middle of the second pass.
    write_word(32'h04030201);
    write_word(32'h08070605);
    FEED_REPEAT = 4'd3; OUT_READY = 1'b1; START_FEED = 1'b1;
    tick();
    START_FEED = 1'b0;
    repeat (11) tick();
    check("pre_clear_valid", DATA_VALID, 1);
    check("pre_clear_count", FIFO_COUNT, 2);
    CLEAR_FIFO = 1'b1;
    tick();
    CLEAR_FIFO = 1'b0;
    fifo_q.delete();
    @(negedge CLK);
    check("clear_valid", DATA_VALID, 0);
    check("clear_count", FIFO_COUNT, 0);
    check("clear_busy", FEED_BUSY, 0);
    check("clear_empty", FIFO_EMPTY, 1);
    done_err = 0;
    repeat (4) begin
      if (FEED_DONE || FEED_BUSY) done_err++;
      @(negedge CLK);
    end
    check("clear_no_done", done_err, 0);
    @(posedge CLK);
    #1;
    START_FEED = 1'b1;
    tick();
    START_FEED = 1'b0;
    done_err = 0;
    repeat (3) begin
      @(negedge CLK);
      if (FEED_BUSY || DATA_VALID || FEED_DONE) done_err++;
    end
    check("empty_start_ignored", done_err, 0);
    @(posedge CLK);
    #1;

    // Asynchronous reset mid-feed.
    write_word(32'h11223344);
    write_word(32'h55667788);
    FEED_REPEAT = 4'd0; OUT_READY = 1'b1; START_FEED = 1'b1;
    tick();
    START_FEED = 1'b0;
    tick();
    #2;
    RESETN = 1'b0;
    #1;
    check("async_rst_valid", DATA_VALID, 0);
    check("async_rst_count", FIFO_COUNT, 0);
    check("async_rst_empty", FIFO_EMPTY, 1);
    check("async_rst_busy", FEED_BUSY, 0);
    check("async_rst_data", IN_ACT_DATA_OUT, 0);
    fifo_q.delete();
    @(negedge CLK);
    RESETN = 1'b1;
    tick();

`ifdef INPUT_ACT_CTRL_PAD_EN
    write_word(32'hD4C3B2A1);
    do_feed(1, 2, 100);
    check("pad_total_beats", got_q.size(), 12);
    if (got_q.size() == 12) begin
      check("pad_beat4_zero", got_q[4], 8'h00);
      check("pad_beat6_data", got_q[6], 8'hA1);
      check("pad_beat11_zero", got_q[11], 8'h00);
    end
    for (int i = 0; i < 3; i++) write_word($urandom);
    do_feed(2, 3, 50);
`endif

    OUT_READY = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_act_ctrl_replay.md
Name: input_act_ctrl_replay

Overview:
Next-generation input activation controller for the mlp_conv datapath. It buffers INPUT_WIDTH words written by the host in a FIFO. On START_FEED it streams each stored word as INPUT_WIDTH/OUTPUT_WIDTH narrow beats, lowest slice first, over a valid/ready handshake. Beyond the previous generation it adds downstream backpressure, a snapshot feed length, and multi-pass replay of the same activations for conv weight reuse; storage is freed only after the final pass.

Parameters:
INPUT_WIDTH, 32, FIFO write word width; must be an integer multiple of OUTPUT_WIDTH.
OUTPUT_WIDTH, 8, beat width toward the PE array.
FIFO_DEPTH, 64, word capacity; power of two, at least 2.
REPEAT_WIDTH, 4, width of the FEED_REPEAT field.

Ports:
CLK  in  1  single clock, rising edge.
RESETN  in  1  asynchronous active-low reset.
CLEAR_FIFO  in  1  synchronous flush plus feed abort.
FIFO_WR_CMD  in  1  write strobe.
FIFO_WR_DATA  in  INPUT_WIDTH  write data.
FIFO_EMPTY  out  1  occupancy == 0.
FIFO_FULL  out  1  occupancy == FIFO_DEPTH.
FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  occupancy.
START_FEED  in  1  feed request, sampled only in IDLE.
FEED_REPEAT  in  REPEAT_WIDTH  extra passes; 0 means a single pass. Sampled with START_FEED.
OUT_READY  in  1  downstream ready.
IN_ACT_DATA_OUT  out  OUTPUT_WIDTH  current beat.
DATA_VALID  out  1  beat valid.
FEED_BUSY  out  1  state != IDLE.
FEED_DONE  out  1  one-cycle pulse after the last beat of the last pass.

Behaviour:
- Reset values: all outputs 0, except FIFO_EMPTY=1. Pointers, counters and state are cleared; state = IDLE.
- Clock and reset: one clock; reset is asynchronous, active-low.
- Occupancy counts every stored word, including words retained for replay. Writes with FIFO_FULL=1 are dropped. FULL is evaluated on the pre-edge count, so a write in the same cycle a word is freed is still dropped.
- If the FIFO is not full, a write and a free in the same cycle both take effect.
- States:
  - IDLE -> FEED on START_FEED && !FIFO_EMPTY. Latch N = FIFO_COUNT, R = FEED_REPEAT, pass_start = rd_ptr.
  - START_FEED with an empty FIFO is ignored; no FEED_DONE is produced.
  - FEED -> DONE after the final beat of pass R.
  - DONE -> IDLE unconditionally; FEED_DONE=1 only in DONE.
- Latency: DATA_VALID rises in the cycle after START_FEED is sampled.
- Handshake: a beat transfers on a rising edge with DATA_VALID && OUT_READY. While OUT_READY=0, IN_ACT_DATA_OUT and DATA_VALID hold stable. DATA_VALID never drops mid-feed.
- Beat order: slice k = word[k*OUTPUT_WIDTH +: OUTPUT_WIDTH], for k = 0 .. S-1, where S = INPUT_WIDTH/OUTPUT_WIDTH.
- Passes:
  - After word N-1 of a non-final pass, rd_ptr rewinds to pass_start with no bubble cycle.
  - On the final pass each word is freed (count decremented) when its slice S-1 transfers.
- Words written during FEED are accepted if not full. They belong to the next feed, not the current one.
- START_FEED outside IDLE is ignored.
- Pointers wrap modulo FIFO_DEPTH; a feed spanning the wrap point is legal.
- CLEAR_FIFO has priority over write, feed and free. Next edge: count=0, pointers=0, state IDLE, DATA_VALID=0, no FEED_DONE.
- RESETN asserted mid-feed behaves like CLEAR_FIFO, but takes effect immediately.

Optional Feature:
INPUT_ACT_CTRL_PAD_EN:
- Defined: adds input port PAD_BEATS[7:0], sampled with START_FEED. After each pass's data, PAD_BEATS zero beats are emitted with DATA_VALID=1 under the same handshake, before the rewind or DONE. PAD_BEATS=0 gives identical behaviour to the non-PAD build.
- Undefined: the port is absent and no pad state or counter is synthesised.

Decomposition:
- Package input_act_pkg: state enum (IDLE, FEED, DONE), plus an optional PAD sub-phase flag. Also holds a localparam helper for S and the pointer width derived from FIFO_DEPTH.
- Sub-module act_replay_buffer: dual-pointer circular RAM. It provides write port, rd_ptr advance, rewind-to-mark, free, count/full/empty, and clear. The top level keeps the FSM, slice counter, pass counter and handshake.

Test Plan:
1. Write 0x44332211 and 0x88776655, START_FEED, REPEAT=0, OUT_READY=1 -> beats 11,22,33,44,55,66,77,88 on 8 consecutive cycles. FEED_DONE pulses once; COUNT=0, EMPTY=1.
2. Same data, REPEAT=2 -> the 8-beat sequence appears 3 times back-to-back (24 beats). COUNT stays 2 until the final pass, then reaches 0.
3. Random OUT_READY (about 50%) over 21 random words -> the byte stream matches the scoreboard exactly, and data is held stable during every stall.
4. Write 64 words -> FULL=1; a 65th write is dropped. During feed, after word 0 frees, a write is accepted and COUNT returns to 64. The new word is not fed in the current feed.
5. CLEAR_FIFO asserted mid pass 1 of REPEAT=3 -> next cycle DATA_VALID=0, COUNT=0, IDLE, and no FEED_DONE. START_FEED on the empty FIFO is then ignored.
6. RESETN pulled low mid-feed -> all outputs immediately at reset values. With PAD_EN and PAD_BEATS=2, REPEAT=1, 1 word -> 4 data beats, 2 zero beats, 4 data beats, 2 zero beats, then FEED_DONE.
